// File: rtl/mux2_pkg.sv
// mux2_pkg: shared select encodings, default sizes and the saturating
// increment helper used by the 2:1 selector and its select monitor.
package mux2_pkg;

  localparam logic SEL_X1 = 1'b0;
  localparam logic SEL_X2 = 1'b1;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 8;

  // Increment count by one, holding at 2^cnt_w-1 instead of wrapping.
  // Works on a 32-bit carrier; callers keep cnt_w in 1..32.
  function automatic logic [31:0] sat_inc(input logic [31:0] count, input int cnt_w);
    logic [32:0] max_v;
    max_v = (33'd1 << cnt_w) - 33'd1;
    if ({1'b0, count} >= max_v) begin
      sat_inc = max_v[31:0];
    end else begin
      sat_inc = count + 32'd1;
    end
  endfunction

endpackage

// File: rtl/mux2_sel_mon.sv
// mux2_sel_mon: registers the select line, flags each change of the
// registered select with a one-cycle pulse and counts those pulses with a
// saturating counter.
module mux2_sel_mon
  import mux2_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S,
  output logic             SEL_CHG,
  output logic [CNT_W-1:0] SW_CNT
);

  logic             s_q_r;
  logic             sel_chg_r;
  logic [CNT_W-1:0] sw_cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Next counter value: step (saturating) only while the change pulse is high.
  always_comb begin
    cnt_next_s = sw_cnt_r;
    if (sel_chg_r) begin
      cnt_next_s = CNT_W'(sat_inc(32'(sw_cnt_r), CNT_W));
    end else begin
      cnt_next_s = sw_cnt_r;
    end
  end

  // Select sample and change pulse. The pulse register holds the result of
  // comparing the incoming sample with the held one, which is exactly
  // "new s_q differs from previous s_q" for the cycle following the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q_r     <= SEL_X1;
      sel_chg_r <= 1'b0;
    end else begin
      s_q_r     <= S;
      sel_chg_r <= (S != s_q_r);
    end
  end

  // Switch counter, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_cnt_r <= {CNT_W{1'b0}};
    end else begin
      sw_cnt_r <= cnt_next_s;
    end
  end

  assign SEL_CHG = sel_chg_r;
  assign SW_CNT  = sw_cnt_r;

endmodule

// File: rtl/mux2_to_1.sv
// mux2_to_1: 2:1 data selector (Y = S ? X2 : X1) with a registered copy of
// the selection (Y_Q) and select-change monitoring (SEL_CHG, SW_CNT).
// Build option MUX2_OUTPUT_REG_EN: when defined, Y is driven from the Y_Q
// register instead of the combinational selection.
module mux2_to_1
  import mux2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X1,
  input  logic [WIDTH-1:0] X2,
  input  logic             S,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_Q,
  output logic             SEL_CHG,
  output logic [CNT_W-1:0] SW_CNT
);

  logic [WIDTH-1:0] sel_s;
  logic [WIDTH-1:0] y_q_r;

  // Combinational data steer.
  always_comb begin
    sel_s = X1;
    if (S == SEL_X2) begin
      sel_s = X2;
    end else begin
      sel_s = X1;
    end
  end

  // One-cycle registered copy of the selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_r <= {WIDTH{1'b0}};
    end else begin
      y_q_r <= sel_s;
    end
  end

  assign Y_Q = y_q_r;

`ifdef MUX2_OUTPUT_REG_EN
  assign Y = y_q_r;
`else
  assign Y = sel_s;
`endif

  mux2_sel_mon #(
    .CNT_W (CNT_W)
  ) u_sel_mon (
    .clk     (clk),
    .rst_n   (rst_n),
    .S       (S),
    .SEL_CHG (SEL_CHG),
    .SW_CNT  (SW_CNT)
  );

endmodule

// File: tb/tb_mux2_to_1.sv
// tb_mux2_to_1: directed plus randomized stimulus for mux2_to_1, checked
// against a behavioural model built from the select history.
module tb_mux2_to_1;

  localparam int WIDTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] X1;
  logic [WIDTH-1:0] X2;
  logic             S;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Y_Q;
  logic             SEL_CHG;
  logic [CNT_W-1:0] SW_CNT;

  int n_cmp;
  int n_err;

  // model state: expected registered data, last sampled select,
  // total select changes seen, whether the latest sample was a change
  logic [WIDTH-1:0] exp_yq;
  logic             last_s;
  int               changes;
  int               latest_chg;
  int               exp_cnt;

  mux2_to_1 #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .X1      (X1),
    .X2      (X2),
    .S       (S),
    .Y       (Y),
    .Y_Q     (Y_Q),
    .SEL_CHG (SEL_CHG),
    .SW_CNT  (SW_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_yq     = '0;
    last_s     = 1'b0;
    changes    = 0;
    latest_chg = 0;
    exp_cnt    = 0;
  endtask

  // One clock of stimulus; starts and ends just after a falling edge.
  task automatic step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    X1 = a;
    X2 = b;
    S  = s;
    #1;
`ifndef MUX2_OUTPUT_REG_EN
    check_val("y_comb", 32'(Y), 32'(s ? b : a));
`endif
    @(posedge clk);
    exp_yq     = s ? b : a;
    latest_chg = (s != last_s) ? 1 : 0;
    last_s     = s;
    changes    = changes + latest_chg;
    exp_cnt    = changes - latest_chg;
    if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;
    @(negedge clk);
    check_val("y_q", 32'(Y_Q), 32'(exp_yq));
    check_val("sel_chg", 32'(SEL_CHG), 32'(latest_chg));
    check_val("sw_cnt", 32'(SW_CNT), 32'(exp_cnt));
`ifdef MUX2_OUTPUT_REG_EN
    check_val("y_reg", 32'(Y), 32'(exp_yq));
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    rst_n = 1'b0;
    X1 = '0;
    X2 = '0;
    S  = 1'b0;

    // reset held with all-zero inputs
    #97;
    check_val("rst_y", 32'(Y), 32'd0);
    check_val("rst_y_q", 32'(Y_Q), 32'd0);
    check_val("rst_sel_chg", 32'(SEL_CHG), 32'd0);
    check_val("rst_sw_cnt", 32'(SW_CNT), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // truth-table style directed steps
    step(4'h1, 4'h0, 1'b0);
    step(4'h1, 4'h0, 1'b1);
    step(4'h1, 4'h1, 1'b1);
    step(4'h0, 4'h0, 1'b0);
    step(4'hA, 4'h5, 1'b1);

    // toggle select long enough to saturate the counter
    for (int i = 0; i < 300; i++) begin
      step(WIDTH'($urandom), WIDTH'($urandom), ~last_s);
    end
    check_val("sat_hold", 32'(SW_CNT), 32'(CNT_MAX));

    // asynchronous reset between clock edges, mid-toggle
    S = ~last_s;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_y_q", 32'(Y_Q), 32'd0);
    check_val("arst_sel_chg", 32'(SEL_CHG), 32'd0);
    check_val("arst_sw_cnt", 32'(SW_CNT), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // first sampled S=1 after release counts as a switch
    step(4'h3, 4'hC, 1'b1);
    step(4'h3, 4'hC, 1'b1);

    // randomized data and select
    for (int i = 0; i < 200; i++) begin
      step(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux2_to_1.md
Name: mux2_to_1

Overview:
- Two-input, one-output selector. Y follows X1 when S=0 and X2 when S=1.
- Adds a registered copy of the output, a select-change strobe and a saturating switch counter for datapath monitoring.
- Sits in small datapath/glue logic wherever a 2:1 data steer is needed.

Parameters:
- WIDTH, 1, bit width of X1, X2, Y and Y_Q.
- CNT_W, 8, width of the select-switch counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- X1  input  WIDTH  data input selected when S=0.
- X2  input  WIDTH  data input selected when S=1.
- S  input  1  select: 0 selects X1, 1 selects X2.
- Y  output  WIDTH  selected data; combinational by default, see Optional Feature.
- Y_Q  output  WIDTH  selected data registered on clk; always one-cycle latency.
- SEL_CHG  output  1  one-cycle pulse when the registered S differs from the previous registered S.
- SW_CNT  output  CNT_W  count of select changes since reset; saturates.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Combinational Y = S ? X2 : X1. No latch; X/Z on S resolves per simulator semantics, and no special handling is required.
- Truth (WIDTH=1): X1=1,X2=0,S=0 -> Y=1; X1=1,X2=0,S=1 -> Y=0; X1=1,X2=1,S=1 -> Y=1; all zero -> Y=0.
- Y_Q: on each rising clk, Y_Q <= (S ? X2 : X1). Latency is exactly 1 cycle.
- s_q: internal register capturing S each cycle.
- SEL_CHG: registered, =1 in the cycle after s_q toggles (s_q != s_q_prev), else 0.
- SW_CNT increments by 1 on each cycle SEL_CHG is asserted. It saturates at 2^CNT_W-1 and does not wrap.
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - Y_Q=0, s_q=0, s_q_prev=0, SEL_CHG=0, SW_CNT=0.
  - Y (combinational mode) is unaffected by reset.
- Reset release: the first sampled S is compared against s_q=0. S=1 at the first edge produces a SEL_CHG pulse and counts one switch.
- Simultaneous data and select change: Y_Q captures the new selection with the new data at the same edge.
- Glitches on S between clock edges affect only combinational Y, never the registered outputs.

Optional Feature:
- Macro MUX2_OUTPUT_REG_EN.
- Defined: Y is driven from the Y_Q register (1-cycle latency, reset value 0), so Y == Y_Q.
- Undefined (default): Y is purely combinational from X1/X2/S with zero latency. Y_Q and the monitor outputs behave identically in both builds.

Decomposition:
- Package mux2_pkg holds:
  - SEL_X1 = 1'b0 and SEL_X2 = 1'b1 select encodings.
  - Default WIDTH and CNT_W localparams.
  - A function sat_inc(count) for saturating increment.
- Sub-module mux2_sel_mon: the S registration, change detection and saturating counter (clk, rst_n, S -> SEL_CHG, SW_CNT).
- Top-level mux2_to_1 contains the select logic, Y_Q and the macro-controlled Y drive.

Test Plan:
- Reset then X1=0,X2=0,S=0 for 100 ns -> Y=0, Y_Q=0, SEL_CHG=0, SW_CNT=0.
- X1=1,X2=0,S=0 -> Y=1 immediately (combinational build); Y_Q=1 after the next rising clk.
- X1=1,X2=0,S=1 -> Y=0; SEL_CHG pulses for exactly one cycle; SW_CNT=1.
- X1=1,X2=1,S=1 -> Y=1, Y_Q=1 next cycle; no SEL_CHG; SW_CNT stays 1.
- Toggle S every cycle for 300 cycles with CNT_W=8 -> SW_CNT saturates at 255 and holds.
- Assert rst_n low mid-toggle between clock edges -> Y_Q, SEL_CHG and SW_CNT go to 0 immediately. Repeat the truth-table checks with MUX2_OUTPUT_REG_EN defined -> Y lags its inputs by one cycle and equals Y_Q.
